pcileech_com_tx64: RTL and testbench

- Transmit-side counterpart of the COM-core 32->64 RX packer with 0x66665555 resync.
- Accepts 64-bit words from the FIFO side and serializes them into a 32-bit stream for the FT601/ETH core: upper half first, then lower half.
- Inserts resync words so the far-end 32->64 packer (same resync rule) always realigns.
- Sits between the 64-bit TX buffer and the 32-bit com TX FIFO, in the clk_com domain.

---
 rtl/pcileech_com_pkg.sv | 8 +
 rtl/pcileech_com_tx_idlecnt.sv | 22 ++
 rtl/pcileech_com_tx64.sv | 138 +++++++++++++
 tb/tb_pcileech_com_tx64.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pcileech_com_pkg.sv
// Shared constants and types for the COM-core 64->32 transmit path.
package pcileech_com_pkg;
  localparam int          COM_DW        = 32;
  localparam int          COM_QW        = 64;
  localparam logic [31:0] COM_RESYNC_DW = 32'h66665555;

  typedef enum logic [1:0] {SYNC, IDLE, HI, LO} com_tx_state_t;
endpackage

// File: rtl/pcileech_com_tx_idlecnt.sv
// Saturating input-idle counter; o_hit flags that the resync threshold was reached.
module pcileech_com_tx_idlecnt #(
  parameter logic [15:0] THRESH = 16'd1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);
  logic [15:0] r_cnt;

  // count idle cycles, clear wins over increment, stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_cnt <= '0;
    else if (i_clr)                       r_cnt <= '0;
    else if (i_inc && r_cnt != 16'hFFFF)  r_cnt <= r_cnt + 16'd1;
  end

  // threshold of zero turns idle resync off entirely
  assign o_hit = (THRESH != 16'd0) && (r_cnt >= THRESH);
endmodule

// File: rtl/pcileech_com_tx64.sv
// 64->32 serializer for the COM TX path (upper dword first) with resync
// insertion so the far-end 32->64 packer always realigns.
// Optional: define PCILEECH_COM_TX_BURSTPAD_EN to pad every burst end with a
// resync sequence (forces FT601 transfer termination).
module pcileech_com_tx64
  import pcileech_com_pkg::*;
#(
  parameter logic [31:0] RESYNC_WORD        = COM_RESYNC_DW,
  parameter int          RESYNC_WORDS       = 2,
  parameter logic [15:0] IDLE_RESYNC_CYCLES = 16'd1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [COM_QW-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [COM_DW-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [31:0]       stat_words,
  output logic              stat_collision
);
  com_tx_state_t     r_state, w_state_nxt;
  logic [COM_QW-1:0] r_hold, w_hold_nxt;
  logic [3:0]        r_scnt, w_scnt_nxt;
  logic [COM_DW-1:0] r_dout, w_dout_nxt;
  logic              r_dout_valid, w_dout_valid_nxt;
  logic [31:0]       r_words;
  logic              r_coll, r_lo_magic;
  logic              w_acc, w_latch, w_din_ready;
  logic              w_idle_hit, w_idle_inc, w_idle_clr;
  logic              w_prev_magic, w_coll_set;

  assign w_acc = r_dout_valid & dout_ready;

  pcileech_com_tx_idlecnt #(.THRESH(IDLE_RESYNC_CYCLES)) u_idlecnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_idle_inc),
    .i_clr (w_idle_clr),
    .o_hit (w_idle_hit)
  );

  // SYNC clears the counter so the resync it triggered is not repeated
  assign w_idle_inc = (r_state == IDLE) & ~din_valid;
  assign w_idle_clr = w_latch | (r_state == SYNC);

  // next-state, hold latch and the registered output image
  always_comb begin
    w_state_nxt      = r_state;
    w_hold_nxt       = r_hold;
    w_scnt_nxt       = r_scnt;
    w_din_ready      = 1'b0;
    w_latch          = 1'b0;
    w_dout_nxt       = '0;
    w_dout_valid_nxt = 1'b0;
    case (r_state)
      SYNC: if (w_acc) begin
        if (r_scnt == 4'(RESYNC_WORDS - 1)) begin
          w_state_nxt = IDLE;
          w_scnt_nxt  = '0;
        end else begin
          w_scnt_nxt  = r_scnt + 4'd1;
        end
      end
      IDLE: begin
        w_din_ready = ~w_idle_hit;
        if (din_valid) begin
          if (w_idle_hit) begin
            w_state_nxt = SYNC;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = HI;
          end
        end
      end
      HI: if (w_acc) w_state_nxt = LO;
      LO: begin
        // taking the next word while the low dword leaves keeps the stream gapless
        w_din_ready = dout_ready;
        if (w_acc) begin
          if (din_valid) begin
            w_latch     = 1'b1;
            w_state_nxt = HI;
          end else begin
`ifdef PCILEECH_COM_TX_BURSTPAD_EN
            w_state_nxt = SYNC;
`else
            w_state_nxt = IDLE;
`endif
          end
        end
      end
    endcase
    if (w_latch) w_hold_nxt = din;
    case (w_state_nxt)
      SYNC: begin w_dout_nxt = RESYNC_WORD;       w_dout_valid_nxt = 1'b1; end
      HI:   begin w_dout_nxt = w_hold_nxt[63:32]; w_dout_valid_nxt = 1'b1; end
      LO:   begin w_dout_nxt = w_hold_nxt[31:0];  w_dout_valid_nxt = 1'b1; end
      IDLE: begin w_dout_nxt = '0;                w_dout_valid_nxt = 1'b0; end
    endcase
  end

  // a magic low dword followed by a magic high dword would look like resync
  assign w_prev_magic = (r_state == LO) ? (r_hold[31:0] == RESYNC_WORD) : r_lo_magic;
  assign w_coll_set   = w_latch && (din[63:32] == RESYNC_WORD) &&
                        (w_prev_magic || din[31:0] == RESYNC_WORD);

  // state, hold, outputs and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SYNC;
      r_hold       <= '0;
      r_scnt       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_words      <= '0;
      r_coll       <= 1'b0;
      r_lo_magic   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_scnt       <= w_scnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      if (w_acc && (r_state == HI || r_state == LO)) r_words <= r_words + 32'd1;
      if (w_coll_set) r_coll <= 1'b1;
      if (r_state == LO && w_acc)  r_lo_magic <= (r_hold[31:0] == RESYNC_WORD);
      else if (r_state == SYNC)    r_lo_magic <= 1'b0;
    end
  end

  assign din_ready      = w_din_ready;
  assign dout           = r_dout;
  assign dout_valid     = r_dout_valid;
  assign stat_words     = r_words;
  assign stat_collision = r_coll;
endmodule

// File: tb/tb_pcileech_com_tx64.sv
// Scoreboard bench for the 64->32 COM TX serializer.
module tb_pcileech_com_tx64;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] din;
  logic        din_valid, din_ready;
  logic [31:0] dout;
  logic        dout_valid, dout_ready;
  logic [31:0] stat_words;
  logic        stat_collision;

  localparam logic [31:0] RS = 32'h66665555;

  pcileech_com_tx64 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .din            (din),
    .din_valid      (din_valid),
    .din_ready      (din_ready),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .stat_words     (stat_words),
    .stat_collision (stat_collision)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] exp_q[$];
  int          pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // every accepted dword must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      else begin
        chk("dout", {32'h0, dout}, {32'h0, exp_q.pop_front()});
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w);
    bit ok;
    exp_q.push_back(w[63:32]);
    exp_q.push_back(w[31:0]);
    din = w;
    din_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (din_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    chk("din_accept", {63'h0, ok}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] c;
    rst_n = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    #12;
    chk("rst_dout",   {32'h0, dout}, 64'h0);
    chk("rst_dvalid", {63'h0, dout_valid}, 64'h0);
    chk("rst_dready", {63'h0, din_ready}, 64'h0);
    chk("rst_words",  {32'h0, stat_words}, 64'h0);
    chk("rst_coll",   {63'h0, stat_collision}, 64'h0);

    // power-up resync pair, then silence
    exp_q.push_back(RS); exp_q.push_back(RS);
    @(negedge clk); rst_n = 1'b1; dout_ready = 1'b1;
    wait_cyc(10);
    chk("sync_drained", 64'(exp_q.size()), 64'd0);
    chk("sync_quiet",   {63'h0, dout_valid}, 64'h0);
    chk("sync_words",   {32'h0, stat_words}, 64'h0);

    // back-to-back stream: four dwords on consecutive cycles
    pop_cyc.delete();
    send(64'h11112222_33334444);
    send(64'h55556666_77778888);
    wait_cyc(6);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);
    chk("stream_count",   64'(pop_cyc.size()), 64'd4);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("stream_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);
    chk("stream_words", {32'h0, stat_words}, 64'd4);

    // backpressure while the high dword is presented
    c = 64'h11112222_33334444;
    dout_ready = 1'b0;
    send(c);
    repeat (5) begin
      @(negedge clk);
      chk("bp_dout",   {32'h0, dout}, {32'h0, c[63:32]});
      chk("bp_dvalid", {63'h0, dout_valid}, 64'd1);
      chk("bp_dready", {63'h0, din_ready}, 64'd0);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    wait_cyc(5);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_words",   {32'h0, stat_words}, 64'd6);

    // long idle forces a resync pair ahead of the next word
    wait_cyc(1100);
    exp_q.push_back(RS); exp_q.push_back(RS);
    send(64'hAAAA0000_0000BBBB);
    wait_cyc(5);
    chk("idle_drained", 64'(exp_q.size()), 64'd0);
    chk("idle_words",   {32'h0, stat_words}, 64'd8);

    // payload aliasing the resync pattern is sent unchanged but flagged
    chk("coll_before", {63'h0, stat_collision}, 64'd0);
    send(64'h01234567_66665555);
    send(64'h66665555_89ABCDEF);
    wait_cyc(5);
    chk("coll_after",   {63'h0, stat_collision}, 64'd1);
    chk("coll_drained", 64'(exp_q.size()), 64'd0);
    chk("coll_words",   {32'h0, stat_words}, 64'd12);

    // reset between HI and LO: the pending low dword must vanish
    send(64'hDEADBEEF_CAFEF00D);
    void'(exp_q.pop_back());
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout",   {32'h0, dout}, 64'h0);
    chk("mid_rst_dvalid", {63'h0, dout_valid}, 64'h0);
    chk("mid_rst_words",  {32'h0, stat_words}, 64'h0);
    chk("mid_rst_coll",   {63'h0, stat_collision}, 64'h0);
    exp_q.push_back(RS); exp_q.push_back(RS);
    @(negedge clk); rst_n = 1'b1;
    wait_cyc(10);
    chk("mid_rst_drained", 64'(exp_q.size()), 64'd0);
    chk("mid_rst_quiet",   {63'h0, dout_valid}, 64'h0);
    chk("mid_rst_words2",  {32'h0, stat_words}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
